mem_arbiter: RTL and testbench

//   Shares one single-port instruction/data memory between the fetch stage (IF) and the memory stage (DM) of the
//   5-stage pipeline. Fixed priority (DM over IF, since DM holds the older instruction). Generates the stall_f/stall_m

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_timer.sv | 27 ++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: idle, serving the data port, serving the fetch port.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_t;

  // Grant winner encoding.
  localparam logic ARB_DM = 1'b1;
  localparam logic ARB_IF = 1'b0;

endpackage

// File: rtl/arb_timer.sv
// Per-transaction watchdog: cleared on grant/completion, counts busy cycles
// without a memory response, flags expiry at TIMEOUT-1 and saturates there.
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  assign expire = (cnt == LAST);

  // Count up while enabled; hold at LAST instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expire)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between fetch (IF)
// and the memory stage (DM). DM wins ties; completion hands the bus straight
// to a waiting requester; a watchdog terminates unanswered transactions.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  arb_state_t    state, state_n;
  logic          d_elig, i_elig;
  logic          busy, fin, tmo, expire;
  logic          grant, win;

  logic          mem_req_n, mem_we_n, if_done_n, d_done_n, bus_err_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;

  // Pipeline stalls: a requester waits until its done pulse.
  assign stall_f = if_req & ~if_done;
  assign stall_m = d_req & ~d_done;

  // A requester is masked in the cycle its own done pulse is high, so the
  // completing side is never regranted immediately.
  assign d_elig = d_req & ~d_done;
  assign i_elig = if_req & ~if_done;

  // A transaction ends on a memory response, or on watchdog expiry without one.
  assign busy = (state != ARB_IDLE);
  assign tmo  = busy & ~mem_ready & expire;
  assign fin  = busy & (mem_ready | expire);

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant | fin),
    .en     (busy & ~mem_ready),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_n;
  end

  // Next state: grant decision (DM first when idle, the other side on completion).
  always_comb begin
    grant   = 1'b0;
    win     = ARB_IF;
    state_n = state;
    case (state)
      ARB_IDLE: begin
        if (d_elig) begin
          grant = 1'b1;
          win   = ARB_DM;
        end else if (i_elig) begin
          grant = 1'b1;
          win   = ARB_IF;
        end
      end
      ARB_BUSY_D: begin
        if (fin && i_elig) begin
          grant = 1'b1;
          win   = ARB_IF;
        end
      end
      ARB_BUSY_I: begin
        if (fin && d_elig) begin
          grant = 1'b1;
          win   = ARB_DM;
        end
      end
      default: ;
    endcase
    if (grant)    state_n = (win == ARB_DM) ? ARB_BUSY_D : ARB_BUSY_I;
    else if (fin) state_n = ARB_IDLE;
  end

  // Output next-values: bus latch on grant, done/err pulses and read data on completion.
  always_comb begin
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    if (grant) begin
      mem_req_n = 1'b1;
      if (win == ARB_DM) begin
        mem_we_n    = d_we;
        mem_addr_n  = d_addr;
        mem_wdata_n = d_wdata;
      end else begin
        mem_we_n    = 1'b0;
        mem_addr_n  = if_addr;
        mem_wdata_n = '0;
      end
    end else if (fin) begin
      mem_req_n = 1'b0;
    end
    d_done_n  = fin & (state == ARB_BUSY_D);
    if_done_n = fin & (state == ARB_BUSY_I);
    bus_err_n = tmo;
    // Timed-out transactions return zero; stores still register mem_rdata.
    if (d_done_n)  d_rdata_n  = mem_ready ? mem_rdata : '0;
    if (if_done_n) if_rdata_n = mem_ready ? mem_rdata : '0;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_done   <= if_done_n;
      d_done    <= d_done_n;
      bus_err   <= bus_err_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): cycle table for the lone load and
// DM/IF contention, hand sequences for back-to-back fetch, timeout, reset abort
// and near-timeout completion.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, d_done, stall_f, stall_m, mem_req, mem_we, bus_err;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        mr;
    logic [31:0] md;
  } in_t;

  typedef struct packed {
    logic        mq;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        idn;
    logic [31:0] ird;
    logic        ddn;
    logic [31:0] drd;
    logic        be;
    logic        sf;
    logic        sm;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    if_req    = v.ir;
    if_addr   = v.ia;
    d_req     = v.dr;
    d_we      = v.dw;
    d_addr    = v.da;
    d_wdata   = v.dd;
    mem_ready = v.mr;
    mem_rdata = v.md;
  endtask

  // Sampling point: mid-cycle, registered outputs settled for this cycle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    out_t act;

    // Test 1: lone load of 0x40, mem_ready 3 cycles after mem_req rises.
    tbl[0]  = '{'{1'b0,32'h0,1'b1,1'b0,32'h40,32'h0,1'b0,32'h0},
                '{1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,1'b1}};
    tbl[1]  = '{'{1'b0,32'h0,1'b1,1'b0,32'h40,32'h0,1'b0,32'h0},
                '{1'b1,1'b0,32'h40,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,1'b1}};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{'{1'b0,32'h0,1'b1,1'b0,32'h40,32'h0,1'b1,32'hDEADBEEF},
                '{1'b1,1'b0,32'h40,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,1'b1}};
    tbl[5]  = '{'{1'b0,32'h0,1'b1,1'b0,32'h40,32'h0,1'b0,32'h0},
                '{1'b0,1'b0,32'h40,32'h0,1'b0,32'h0,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0}};
    tbl[6]  = '{'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0},
                '{1'b0,1'b0,32'h40,32'h0,1'b0,32'h0,1'b0,32'hDEADBEEF,1'b0,1'b0,1'b0}};
    // Test 2: store 0x1234 to 0x80 races fetch of 0x00; DM first, IF handed over with no gap.
    tbl[7]  = '{'{1'b1,32'h0,1'b1,1'b1,32'h80,32'h1234,1'b0,32'h0},
                '{1'b0,1'b0,32'h40,32'h0,1'b0,32'h0,1'b0,32'hDEADBEEF,1'b0,1'b1,1'b1}};
    tbl[8]  = '{'{1'b1,32'h0,1'b1,1'b1,32'h80,32'h1234,1'b1,32'h55},
                '{1'b1,1'b1,32'h80,32'h1234,1'b0,32'h0,1'b0,32'hDEADBEEF,1'b0,1'b1,1'b1}};
    tbl[9]  = '{'{1'b1,32'h0,1'b1,1'b1,32'h80,32'h1234,1'b0,32'h0},
                '{1'b1,1'b0,32'h0,32'h0,1'b0,32'h0,1'b1,32'h55,1'b0,1'b1,1'b0}};
    tbl[10] = '{'{1'b1,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h13},
                '{1'b1,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h55,1'b0,1'b1,1'b0}};
    tbl[11] = '{'{1'b1,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0},
                '{1'b0,1'b0,32'h0,32'h0,1'b1,32'h13,1'b0,32'h55,1'b0,1'b0,1'b0}};
    // Stray mem_ready while idle must do nothing.
    tbl[12] = '{'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h77},
                '{1'b0,1'b0,32'h0,32'h0,1'b0,32'h13,1'b0,32'h55,1'b0,1'b0,1'b0}};
    tbl[13] = '{'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0},
                '{1'b0,1'b0,32'h0,32'h0,1'b0,32'h13,1'b0,32'h55,1'b0,1'b0,1'b0}};

    // Reset state.
    reset = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dones", {if_done, d_done, bus_err}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      step();
      drive(tbl[k].i);
      #1;
      act = '{mem_req, mem_we, mem_addr, mem_wdata, if_done, if_rdata,
              d_done, d_rdata, bus_err, stall_f, stall_m};
      if (act !== tbl[k].o) begin
        failures++;
        $display("FAIL vec%0d: got %h expected %h", k, act, tbl[k].o);
      end
      checks++;
    end

    // Test 3: back-to-back fetch, next address presented during the done cycle.
    step(); if_req = 1'b1; if_addr = 32'h100;
    step(); chk("b2b_req1", mem_req, 1); chk("b2b_addr1", mem_addr, 32'h100);
    step(); mem_ready = 1'b1; mem_rdata = 32'hA1;
    step(); chk("b2b_done1", if_done, 1); chk("b2b_rdata1", if_rdata, 32'hA1);
            chk("b2b_req_drop", mem_req, 0);
            mem_ready = 1'b0; if_addr = 32'h104;
    step(); chk("b2b_no_regrant", mem_req, 0); chk("b2b_done_pulse", if_done, 0);
            chk("b2b_stall_f", stall_f, 1);
    step(); chk("b2b_req2", mem_req, 1); chk("b2b_addr2", mem_addr, 32'h104);
            mem_ready = 1'b1; mem_rdata = 32'hA2;
    step(); chk("b2b_done2", if_done, 1); chk("b2b_rdata2", if_rdata, 32'hA2);
            if_req = 1'b0; mem_ready = 1'b0;

    // Test 4: timeout after 4 busy cycles, then a late mem_ready.
    step(); if_req = 1'b1; if_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tmo_busy_req", mem_req, 1);
      chk("tmo_busy_done", {if_done, bus_err}, 0);
    end
    step(); chk("tmo_done", if_done, 1); chk("tmo_bus_err", bus_err, 1);
            chk("tmo_rdata", if_rdata, 0); chk("tmo_mem_req", mem_req, 0);
    step(); if_req = 1'b0; chk("tmo_pulse_end", {if_done, bus_err}, 0);
    step(); mem_ready = 1'b1; mem_rdata = 32'hBAD;
    step(); mem_ready = 1'b0;
            chk("tmo_late_ready", {if_done, d_done, bus_err, mem_req}, 0);
    step(); chk("tmo_late_ready2", {if_done, d_done}, 0);

    // Test 5: reset while DM store is outstanding.
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE;
    step(); chk("rmid_req", {mem_req, mem_we}, 2'b11); chk("rmid_addr", mem_addr, 32'h300);
            reset = 1'b1;
    step(); reset = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1111;
            chk("rmid_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
            chk("rmid_flags", {if_done, d_done, bus_err}, 0);
            chk("rmid_rdata", {if_rdata, d_rdata}, 0);
    step(); mem_ready = 1'b0; chk("rmid_no_done", {d_done, mem_req}, 0);
    step(); chk("rmid_no_done2", d_done, 0);

    // Test 6: response after TIMEOUT-2 idle cycles completes normally.
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = 32'h0;
    step(); chk("near_req", mem_req, 1);
    step();
    step(); mem_ready = 1'b1; mem_rdata = 32'h600D;
    step(); mem_ready = 1'b0;
            chk("near_done", d_done, 1); chk("near_bus_err", bus_err, 0);
            chk("near_rdata", d_rdata, 32'h600D); chk("near_mem_req", mem_req, 0);
    step(); d_req = 1'b0; chk("near_pulse_end", d_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
